// File: rtl/axi_read_adapter_pkg.sv
// Shared constants, AXI encodings and FSM state type for the AXI3 read-channel adapter.
package axi_read_adapter_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Valid     = 1'b1;
  localparam logic InValid   = 1'b0;
  localparam logic Ready     = 1'b1;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    READ_IDLE,
    READ_ADDR,
    READ_DATA
  } read_state_e;

endpackage

// File: rtl/axi_read_adapter.sv
// AXI3 read master: one pipeline read request becomes one AR handshake and its R beat(s).
// Define AXI_READ_BURST_EN to add the len input, multi-beat reads and the last_beat output.
module axi_read_adapter
  import axi_read_adapter_pkg::*;
#(
  parameter logic [3:0]  ARID_VAL   = 4'b0000,
  parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  input  logic        re,
  input  logic [31:0] address,
`ifdef AXI_READ_BURST_EN
  input  logic [3:0]  len,
  output logic        last_beat,
`endif
  output logic [31:0] data,
  output logic        mem_read_valid,
  output logic        busy,
  output logic        read_error
);

  read_state_e state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        busy_q, busy_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        final_beat;

`ifdef AXI_READ_BURST_EN
  logic [3:0] arlen_q, arlen_d;
  logic [3:0] beat_q, beat_d;
  logic       last_q, last_d;
  logic       unused_rid;

  assign unused_rid = ^rid;
  assign final_beat = (beat_q == arlen_q);
  assign arlen      = arlen_q;
  assign last_beat  = last_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{rid, rlast};
  assign final_beat    = 1'b1;
  assign arlen         = 4'd0;
`endif

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    data_d    = data_q;
    valid_d   = InValid;
    error_d   = 1'b0;
`ifdef AXI_READ_BURST_EN
    arlen_d   = arlen_q;
    beat_d    = beat_q;
    last_d    = 1'b0;
`endif
    unique case (state_q)
      READ_IDLE: begin
        // valid_q high means busy fell this cycle; such a request is not taken
        if (re && !valid_q) begin
          araddr_d  = address;
          arvalid_d = Valid;
          busy_d    = 1'b1;
          state_d   = READ_ADDR;
`ifdef AXI_READ_BURST_EN
          arlen_d   = len;
          beat_d    = 4'd0;
`endif
        end
      end
      READ_ADDR: begin
        if (arvalid_q && arready) begin
          arvalid_d = InValid;
          rready_d  = Ready;
          state_d   = READ_DATA;
        end
      end
      READ_DATA: begin
        if (rvalid && rready_q) begin
          data_d  = rdata;
          valid_d = Valid;
          error_d = (rresp != RESP_OKAY);
`ifdef AXI_READ_BURST_EN
          error_d = error_d || (rlast != final_beat);
          last_d  = final_beat;
          beat_d  = beat_q + 4'd1;
`endif
          if (final_beat) begin
            rready_d = InValid;
            busy_d   = 1'b0;
            state_d  = READ_IDLE;
          end
        end
      end
      default: state_d = READ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset == RstEnable) begin
      state_q   <= READ_IDLE;
      araddr_q  <= 32'd0;
      arvalid_q <= InValid;
      rready_q  <= InValid;
      busy_q    <= 1'b0;
      data_q    <= RESET_DATA;
      valid_q   <= InValid;
      error_q   <= 1'b0;
`ifdef AXI_READ_BURST_EN
      arlen_q   <= 4'd0;
      beat_q    <= 4'd0;
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
`ifdef AXI_READ_BURST_EN
      arlen_q   <= arlen_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
`endif
    end
  end

  assign arid           = ARID_VAL;
  assign araddr         = araddr_q;
  assign arsize         = SIZE_4B;
  assign arburst        = BURST_INCR;
  assign arlock         = 2'b00;
  assign arcache        = 4'b0000;
  assign arprot         = 3'b000;
  assign arvalid        = arvalid_q;
  assign rready         = rready_q;
  assign data           = data_q;
  assign mem_read_valid = valid_q;
  assign busy           = busy_q;
  assign read_error     = error_q;

endmodule

// File: tb/tb_axi_read_adapter.sv
// Directed bench for axi_read_adapter with a queue scoreboard of expected read results.
// Define AXI_READ_BURST_EN to also exercise multi-beat reads.
module tb_axi_read_adapter;

  logic        clk;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        re;
  logic [31:0] address;
  logic [31:0] data;
  logic        mem_read_valid;
  logic        busy;
  logic        read_error;
`ifdef AXI_READ_BURST_EN
  logic [3:0]  len;
  logic        last_beat;
`endif

  axi_read_adapter dut (
    .clk            (clk),
    .reset          (reset),
    .arid           (arid),
    .araddr         (araddr),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .arlock         (arlock),
    .arcache        (arcache),
    .arprot         (arprot),
    .arvalid        (arvalid),
    .arready        (arready),
    .rid            (rid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rlast          (rlast),
    .rvalid         (rvalid),
    .rready         (rready),
    .re             (re),
    .address        (address),
`ifdef AXI_READ_BURST_EN
    .len            (len),
    .last_beat      (last_beat),
`endif
    .data           (data),
    .mem_read_valid (mem_read_valid),
    .busy           (busy),
    .read_error     (read_error)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   ar_hs    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic l);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.last = l;
    sb.push_back(x);
  endtask

  // Scoreboard side: every completion pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && arvalid && arready) ar_hs++;
    if (mem_read_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_pulse: observed data %h with empty scoreboard", data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", data, e.data);
        chk("sb_read_error", read_error, e.err);
`ifdef AXI_READ_BURST_EN
        chk("sb_last_beat", last_beat, e.last);
`endif
      end
    end else if (read_error) begin
      chk("error_without_valid", read_error, 1'b0);
    end
  end

  initial begin
    reset   = 1'b1;
    arready = 1'b0;
    rid     = 4'h5;
    rdata   = 32'd0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    re      = 1'b0;
    address = 32'd0;
`ifdef AXI_READ_BURST_EN
    len     = 4'd0;
`endif
    repeat (2) step();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", mem_read_valid, 1'b0);
    chk("rst_error", read_error, 1'b0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("const_ar", {arid, arsize, arburst, arlock, arcache, arprot},
        {4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000});
    reset = 1'b0;
    step();

    // 1: basic minimum-latency read
    re = 1'b1;
    address = 32'h1FC0_0000;
    step();
    re = 1'b0;
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    chk("t1_busy", busy, 1'b1);
    chk("t1_arlen", arlen, 4'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("t1_rready", rready, 1'b1);
    chk("t1_arvalid_low", arvalid, 1'b0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    rlast  = 1'b1;
    push(32'hDEAD_BEEF, 1'b0, 1'b1);
    step();
    rvalid = 1'b0;
    chk("t1_valid", mem_read_valid, 1'b1);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_rready_low", rready, 1'b0);
    step();
    chk("t1_valid_clear", mem_read_valid, 1'b0);

    // 2: AR backpressure
    re = 1'b1;
    address = 32'h0000_2000;
    step();
    re = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_held", arvalid, 1'b1);
      chk("t2_araddr_held", araddr, 32'h0000_2000);
      chk("t2_rready_low", rready, 1'b0);
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("t2_rready", rready, 1'b1);
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    push(32'h1234_5678, 1'b0, 1'b1);
    step();
    rvalid = 1'b0;
    step();

    // 3: early rvalid and re while busy are ignored
    re = 1'b1;
    address = 32'h0000_0100;
    step();
    address = 32'h8000_0004;
    rvalid  = 1'b1;
    rdata   = 32'h1111_1111;
    step();
    chk("t3_early_rready", rready, 1'b0);
    chk("t3_early_valid", mem_read_valid, 1'b0);
    chk("t3_araddr_kept", araddr, 32'h0000_0100);
    rvalid  = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("t3_no_second_ar", arvalid, 1'b0);
    rvalid = 1'b1;
    rdata  = 32'h2222_2222;
    push(32'h2222_2222, 1'b0, 1'b1);
    step();
    rvalid = 1'b0;
    step();
    chk("t3_fall_cycle_re_ignored", arvalid, 1'b0);
    chk("t3_idle", busy, 1'b0);
    re = 1'b0;
    step();

    // 4: error response
    re = 1'b1;
    address = 32'h0000_0300;
    step();
    re = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h0;
    rresp  = 2'b10;
    push(32'h0, 1'b1, 1'b1);
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    chk("t4_error", read_error, 1'b1);
    chk("t4_busy_low", busy, 1'b0);
    step();
    chk("t4_error_clear", read_error, 1'b0);

    // 5: reset in DATA abandons the read
    re = 1'b1;
    address = 32'h0000_0040;
    step();
    re = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("t5_in_data", rready, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_rst_arvalid", arvalid, 1'b0);
    chk("t5_rst_rready", rready, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    rvalid = 1'b1;
    rdata  = 32'h5555_5555;
    step();
    reset  = 1'b0;
    step();
    rvalid = 1'b0;
    chk("t5_late_beat_dropped", data, 32'd0);
    re = 1'b1;
    address = 32'h0000_0010;
    step();
    re = 1'b0;
    chk("t5_araddr", araddr, 32'h0000_0010);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_0010;
    push(32'hCAFE_0010, 1'b0, 1'b1);
    step();
    rvalid = 1'b0;
    step();

`ifdef AXI_READ_BURST_EN
    // 6: four-beat bursts, well-formed then with early rlast
    for (int run = 0; run < 2; run++) begin
      re = 1'b1;
      len = 4'd3;
      address = 32'h0000_1000;
      step();
      re = 1'b0;
      chk("t6_arlen", arlen, 4'd3);
      arready = 1'b1;
      step();
      arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        rvalid = 1'b1;
        rdata  = 32'hA0 + i;
        rlast  = (run == 0) ? (i == 3) : (i == 2);
        push(32'hA0 + i, (run == 1) && (i >= 2), i == 3);
        step();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      chk("t6_busy_low", busy, 1'b0);
      step();
    end
`endif

    step();
    chk("sb_empty", sb.size(), 0);
`ifdef AXI_READ_BURST_EN
    chk("pulse_count", pulses, 13);
    chk("ar_handshakes", ar_hs, 8);
`else
    chk("pulse_count", pulses, 5);
    chk("ar_handshakes", ar_hs, 6);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_read_adapter.md
Name: axi_read_adapter

Overview:
- AXI3 read-channel master (AR + R) for the core's instruction-fetch and load paths.
- Companion to the write-channel adapter, on the same AXI interconnect port.
- Turns a one-cycle read request (re, address) from the pipeline into one AR handshake and one R transfer.
- Returns registered read data with a one-cycle completion pulse. One outstanding transaction at a time.

Parameters:
- ARID_VAL, 4'b0000, constant driven on arid; rid is not checked.
- RESET_DATA, 32'h0000_0000, value of data after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- arid  out  4  = ARID_VAL
- araddr  out  32  latched request address
- arlen  out  4  0 (single beat); burst length with the optional feature
- arsize  out  3  3'b010 (4 bytes)
- arburst  out  2  2'b01 (INCR)
- arlock  out  2  0
- arcache  out  4  0
- arprot  out  3  0
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  response code
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data accept
- re  in  1  read request pulse from mem/if
- address  in  32  request address, sampled with re
- data  out  32  returned word, registered
- mem_read_valid  out  1  one-cycle pulse: data holds the new word
- busy  out  1  high from request acceptance until the final beat is taken
- read_error  out  1  one-cycle pulse, coincident with mem_read_valid, when rresp != 2'b00

Behaviour:
- Reset (asynchronous): state IDLE; arvalid=0, rready=0, busy=0, mem_read_valid=0, read_error=0, araddr=0, data=RESET_DATA.
- The FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - re=1 → latch araddr<=address, arvalid<=1, busy<=1, go to ADDR.
  - mem_read_valid and read_error clear on the cycle after their pulse.
- ADDR:
  - arvalid and araddr are held stable until arvalid&&arready.
  - On that handshake: arvalid<=0, rready<=1, go to DATA.
  - If arready is already high on the first ADDR cycle, the handshake completes in that cycle.
- DATA:
  - rready is held at 1.
  - On rvalid&&rready: data<=rdata, mem_read_valid<=1, read_error<=(rresp!=0).
  - Then rready<=0, busy<=0, go to IDLE.
  - In single-beat mode rlast is ignored.
- rvalid arriving before the AR handshake completes is not accepted (rready=0).
- Minimum latency: re at cycle 0 → arvalid at 1. With arready=1 at 1 and rvalid=1 at 2, mem_read_valid is high at 3 and busy is low at 3.
- re while busy=1 is ignored; the requester holds re until busy is low.
- re in the same cycle that busy falls is also ignored; it is accepted from the next cycle onward.
- Reset mid-transaction abandons the transaction. No late R beat is accepted after reset because rready=0.

Optional Feature:
- Macro: AXI_READ_BURST_EN.
- Defined:
  - Adds input len[3:0]; arlen is latched from len with re.
  - A 4-bit beat counter counts accepted R beats; mem_read_valid pulses per beat and data updates per beat.
  - Adds output last_beat (1 with the final pulse).
  - The transaction ends when the counter reaches arlen.
  - read_error also pulses if rlast disagrees with the counter on any beat.
- Undefined: no len port, arlen fixed at 0, single-beat behaviour as above.

Decomposition:
- Shared package/defines:
  - RstEnable, Valid/InValid, Ready.
  - State encodings READ_IDLE/READ_ADDR/READ_DATA.
  - AXI constants: SIZE_4B, BURST_INCR, RESP_OKAY.
- No sub-module. The burst counter stays inline.

Test Plan:
1. Basic read: re=1, address=0x1FC0_0000; arready=1 next cycle; rvalid=1, rdata=0xDEAD_BEEF, rresp=0 two cycles later → araddr=0x1FC0_0000, data=0xDEAD_BEEF, one mem_read_valid pulse, read_error=0, busy low after.
2. Backpressure: arready held low 5 cycles → arvalid and araddr stable for all 5 cycles; handshake on cycle 6; rready rises only after it.
3. Early/ignored inputs: rvalid=1 with rdata=0x1111_1111 before the AR handshake → not accepted; a second re with address=0x8000_0004 while busy → no second AR.
4. Error response: rresp=2'b10 with rdata=0x0 → read_error and mem_read_valid pulse together, FSM returns to IDLE.
5. Reset mid-operation: assert reset in DATA state → arvalid=0, rready=0, busy=0 immediately; a next request at 0x0000_0010 completes normally.
6. Burst (AXI_READ_BURST_EN): len=3, rdata 0xA0..0xA3 with rlast on the 4th beat → four pulses, last_beat on the 4th; rlast on the 3rd beat → read_error.
